// File: rtl/top.sv
// Transition detector: two combinational copies of in_signal, plus a 3-flop
// synchroniser driving rise/fall strobes and a saturating transition counter.
module top #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_signal,
  output logic             out_signal1,
  output logic             out_signal2,
  output logic             in_q,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count
);

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise, w_fall, w_sat;

  // The copies bypass every flop so they stay live through reset and without a clock.
  assign out_signal1 = in_signal;
  assign out_signal2 = in_signal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= in_signal;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_sat  = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if ((w_rise | w_fall) && !w_sat)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign in_q       = r_s2;
  assign rise_pulse = w_rise;
  assign fall_pulse = w_fall;
  assign edge_count = r_cnt;

endmodule

// File: tb/tb_top.sv
// Bench for top: combinational copy table, reset behaviour, strobe scoreboard
// and saturating counter checks on a default and a CNT_W=2 instance.
module tb_top;

  logic        clk, rst, in_signal;
  logic        out_signal1, out_signal2, in_q, rise_pulse, fall_pulse;
  logic [15:0] edge_count;
  logic        b_out1, b_out2, b_in_q, b_rise, b_fall;
  logic [1:0]  b_count;

  top dut (
    .clk(clk), .rst(rst), .in_signal(in_signal),
    .out_signal1(out_signal1), .out_signal2(out_signal2), .in_q(in_q),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .edge_count(edge_count)
  );

  top #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_signal(in_signal),
    .out_signal1(b_out1), .out_signal2(b_out2), .in_q(b_in_q),
    .rise_pulse(b_rise), .fall_pulse(b_fall), .edge_count(b_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rise = 0;
  int n_fall = 0;
  bit clk_en = 0;
  bit mon_en = 0;

  typedef struct { bit in; bit exp; } comb_t;
  typedef struct { bit in; int c16; int c2; } tog_t;
  typedef struct { int due; bit rise; } ev_t;

  ev_t sb[$];
  ev_t e_pop;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Each toggle is queued with the cycle at which its strobe must be visible.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rise_pulse && fall_pulse) chk("pulse_overlap", 1, 0);
      if (rise_pulse) n_rise++;
      if (fall_pulse) n_fall++;
      if (rise_pulse || fall_pulse) begin
        if (sb.size() == 0) chk("spurious_pulse", 1, 0);
        else begin
          e_pop = sb.pop_front();
          chk("pulse_cycle", cyc, e_pop.due);
          chk("pulse_dir_rise", int'(rise_pulse), int'(e_pop.rise));
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missed_pulse", cyc, sb[0].due);
        e_pop = sb.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    comb_t comb[6];
    tog_t  tog[10];
    comb = '{'{1'b0,1'b0}, '{1'b1,1'b1}, '{1'b0,1'b0},
             '{1'b1,1'b1}, '{1'b1,1'b1}, '{1'b0,1'b0}};
    tog  = '{'{1'b1,1,1}, '{1'b0,2,2}, '{1'b1,3,3}, '{1'b0,4,3}, '{1'b1,5,3},
             '{1'b0,6,3}, '{1'b1,7,3}, '{1'b0,8,3}, '{1'b1,9,3}, '{1'b0,10,3}};

    clk = 0;
    in_signal = 0;

    // Copies with no clock running and rst never driven.
    for (int i = 0; i < 6; i++) begin
      in_signal = comb[i].in;
      #1;
      chk("out1_noclk", int'(out_signal1), int'(comb[i].exp));
      chk("out2_noclk", int'(out_signal2), int'(comb[i].exp));
    end

    // Held in reset with the clock running.
    rst = 1;
    #1;
    clk_en = 1;
    for (int i = 0; i < 4; i++) begin
      in_signal = ~in_signal;
      @(negedge clk);
      chk("rst_out1", int'(out_signal1), int'(in_signal));
      chk("rst_out2", int'(out_signal2), int'(in_signal));
      chk("rst_in_q", int'(in_q), 0);
      chk("rst_pulses", int'(rise_pulse | fall_pulse), 0);
      chk("rst_count", int'(edge_count), 0);
    end

    // Release with in=0, raise before edge 1.
    in_signal = 0;
    @(negedge clk);
    rst = 0;
    in_signal = 1;
    @(negedge clk);
    chk("rel_e1_in_q", int'(in_q), 0);
    chk("rel_e1_rise", int'(rise_pulse), 0);
    @(negedge clk);
    chk("rel_e2_in_q", int'(in_q), 1);
    chk("rel_e2_rise", int'(rise_pulse), 1);
    chk("rel_e2_count", int'(edge_count), 0);
    @(negedge clk);
    chk("rel_e3_rise", int'(rise_pulse), 0);
    chk("rel_e3_count", int'(edge_count), 1);

    // Ten toggles, four cycles apart; both counter widths checked per step.
    rst = 1;
    in_signal = 0;
    #1;
    rst = 0;
    repeat (3) @(negedge clk);
    sb.delete();
    n_rise = 0;
    n_fall = 0;
    mon_en = 1;
    for (int i = 0; i < 10; i++) begin
      in_signal = tog[i].in;
      sb.push_back('{cyc + 2, tog[i].in});
      repeat (4) @(negedge clk);
      chk("tog_count16", int'(edge_count), tog[i].c16);
      chk("tog_count2", int'(b_count), tog[i].c2);
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("rise_strobes", n_rise, 5);
    chk("fall_strobes", n_fall, 5);
    mon_en = 0;

    // Count to 7, leave a transition in flight, then reset mid-cycle.
    rst = 1;
    in_signal = 0;
    #1;
    rst = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      in_signal = ~in_signal;
      repeat (4) @(negedge clk);
    end
    chk("pre_rst_count", int'(edge_count), 7);
    chk("pre_rst_in_q", int'(in_q), 1);
    in_signal = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("async_in_q", int'(in_q), 0);
    chk("async_pulses", int'(rise_pulse | fall_pulse), 0);
    chk("async_count", int'(edge_count), 0);
    chk("async_count2", int'(b_count), 0);
    chk("async_out1", int'(out_signal1), int'(in_signal));
    in_signal = 1;
    #1;
    chk("async_out2", int'(out_signal2), 1);
    @(negedge clk);
    chk("held_in_q", int'(in_q), 0);
    chk("held_count", int'(edge_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
